// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: fetch-stage PC with single-delay-slot redirect, stall-held pending target and branch counters
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        ex_ctrl,
    input  logic        take_branch,
    input  logic [31:0] ex_target,
    input  logic        clear_counters,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        redirect,
    output logic        misaligned,
    output logic [31:0] branch_count,
    output logic [31:0] taken_count
);
    typedef enum logic {RUN, PENDING} state_t;

    state_t      state;
    logic [31:0] pend_target;
    logic        taken;
    logic [31:0] aligned;

    assign taken    = ex_ctrl & take_branch;
    assign aligned  = {ex_target[31:2], 2'b00};
    assign pc_plus4 = pc + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            pc           <= RESET_PC;
            pend_target  <= '0;
            redirect     <= 1'b0;
            misaligned   <= 1'b0;
            branch_count <= '0;
            taken_count  <= '0;
        end else begin
            redirect   <= 1'b0;
            misaligned <= 1'b0;
            // a taken event while PENDING is counted but its target is dropped
            if (state == PENDING) begin
                if (!stall) begin
                    pc       <= pend_target;
                    redirect <= 1'b1;
                    state    <= RUN;
                end
            end else if (taken) begin
                misaligned <= |ex_target[1:0];
                if (stall) begin
                    pend_target <= aligned;
                    state       <= PENDING;
                end else begin
                    pc       <= aligned;
                    redirect <= 1'b1;
                end
            end else if (!stall) begin
                pc <= pc_plus4;
            end
            branch_count <= clear_counters ? '0 : branch_count + {31'd0, ex_ctrl};
            taken_count  <= clear_counters ? '0 : taken_count + {31'd0, taken};
        end
    end
endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Fetch-stage program-counter unit for the 3-stage MIPS150 pipeline (IF, EX, MEM/WB). It consumes the execute-stage branch decision (`take_branch`) and target, and drives the word-aligned fetch PC to instruction memory. The unit preserves the MIPS single-delay-slot semantics and holds a pending redirect across instruction-memory stalls. It also keeps branch/taken performance counters.

## Interface

Parameters:
- `RESET_PC`, 32'h4000_0000, fetch address loaded on reset.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `stall`  input  1  fetch hold (IMEM busy). Holds only the fetch stage: EX advances every cycle, and EX inputs are valid for one cycle only.
- `ex_ctrl`  input  1  the instruction in EX is a branch or jump (beq/bne/blez/bgtz/bltz/bgez/j/jal/jr/jalr).
- `take_branch`  input  1  EX branch decision; qualified by `ex_ctrl`. Jumps arrive with `take_branch`=1.
- `ex_target`  input  32  resolved target (branch offset, jump concat or register).
- `clear_counters`  input  1  synchronous clear of both counters.
- `pc`  output  32  current fetch address; registered.
- `pc_plus4`  output  32  `pc`+4, combinational, modulo 2^32.
- `redirect`  output  1  registered; high the single cycle in which `pc` first shows a branch target.
- `misaligned`  output  1  registered one-cycle pulse: the accepted target had a nonzero `ex_target[1:0]`.
- `branch_count`  output  32  number of `ex_ctrl` cycles seen.
- `taken_count`  output  32  number of `ex_ctrl & take_branch` cycles seen.

## Operation

Definitions:
- A cycle is a **taken event** when `ex_ctrl & take_branch` = 1.
- Every loaded target is word-aligned: `ex_target & ~32'h3`.

Reset (`rst`=1, any state, including mid-PENDING), applied at the next edge:
- `pc`=`RESET_PC`, state=RUN.
- `redirect`=0, `misaligned`=0.
- Both counters=0.
- The pending target is discarded.

State machine:
- **RUN**
  - Taken event & ~`stall`: `pc`←aligned target; `redirect`←1; stay in RUN.
  - Taken event & `stall`: latch the aligned target into `pend_target`; `pc` held; go to PENDING.
  - No taken event & ~`stall`: `pc`←`pc`+4.
  - No taken event & `stall`: `pc` held.
- **PENDING**
  - ~`stall`: `pc`←`pend_target`; `redirect`←1; go to RUN.
  - `stall`: `pc` held; stay in PENDING.
  - A taken event while PENDING (a branch in the delay slot) is architecturally undefined. Its target is ignored: the first target wins. It is still counted.

Delay slot:
- The instruction fetched in the cycle of the taken event is the delay slot and executes normally.
- No flush is generated.

`misaligned`:
- Pulses on the edge at which a target is latched, whether loaded directly or into `pend_target`, when `ex_target[1:0]`≠0.
- It does not pulse for an ignored target.

Counters:
- Each counter increments by 1 per qualifying cycle, regardless of `stall` or state.
- Both wrap from 32'hFFFF_FFFF to 0.
- `clear_counters` has priority: on a simultaneous event the counter becomes 0 and the event is lost.
- `rst` also clears both counters.

PC arithmetic: wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).

## Timing

- Taken event at edge N with no stall: `pc`=target and `redirect`=1 during cycle N+1.
- Taken event with `stall` high for cycles N..N+k-1 and low at N+k: `pc` held through N+k; `pc`=target and `redirect`=1 during N+k+1.
- `redirect` and `misaligned` are single-cycle pulses, never high two consecutive cycles from one event.
- `pc_plus4` follows `pc` with zero latency.
- Counters update at the edge ending the event cycle and are visible the next cycle.
- After `rst` deasserts, the first fetch is `RESET_PC`. `pc` advances at the first non-stalled edge.

## Test plan

1. Reset, then 4 unstalled cycles with no branch: `pc` = 4000_0000, 4000_0004, 4000_0008, 4000_000C, 4000_0010. `redirect`=0 throughout.

2. At `pc`=4000_0010, pulse `ex_ctrl`=`take_branch`=1 with `ex_target`=4000_0100:
   - Next cycle `pc`=4000_0100, `redirect`=1.
   - Following cycle `pc`=4000_0104, `redirect`=0.
   - `branch_count`=1, `taken_count`=1.

3. Taken event with target 4000_0200 while `stall`=1, held 3 cycles:
   - `pc` frozen for the 3 stall cycles plus the first unstalled cycle.
   - Then `pc`=4000_0200 with `redirect`=1 for one cycle.
   - A second taken event (target 4000_0300) issued during the stall is ignored: `pc` still goes to 4000_0200, and `taken_count` increases by 2.

4. Not-taken branch (`ex_ctrl`=1, `take_branch`=0) with `ex_target`=4000_0500: `pc` continues sequentially; `branch_count`+1; `taken_count` unchanged.

5. Taken event with `ex_target`=4000_0603: `pc`=4000_0600 next cycle; `misaligned` and `redirect` pulse together for 1 cycle.

6. Edge cases:
   - Preload `taken_count` to FFFF_FFFF, then one taken event: counter reads 0.
   - Taken event with `clear_counters`=1 in the same cycle: both counters read 0.
   - Assert `rst` while in PENDING: next cycle `pc`=4000_0000, state RUN. The pending target is never loaded after `stall` drops.
